// File: rtl/decode_ctrl_stage.sv
// RV32I control/decode stage: one registered slot with valid/ready handshake,
// flush, illegal-instruction detection and a saturating illegal counter.
module decode_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_instr_word,
  input  logic                  i_flush,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_branch,
  output logic                  o_jump,
  output logic                  o_alu_src_imm,
  output logic [XLEN-1:0]       o_imm,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [4:0]            o_rd,
  output logic [2:0]            o_funct3,
  output logic                  o_illegal,
  output logic [CNT_W-1:0]      o_illegal_count
);

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(4'b0011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(4'b0100);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(4'b0101);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4'b0111);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(4'b1000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(4'b1001);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4'b1010);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 -> ALU op; alt selects SUB/SRA for the 000/101 encodings
  function automatic logic [ALU_CTRL_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic [XLEN-1:0]       w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [ALU_CTRL_W-1:0] w_alu;
  logic                  w_rw, w_mr, w_mw, w_br, w_jp, w_src, w_ill;
  logic [XLEN-1:0]       w_imm;
  logic                  w_accept;

  logic                  r_out_valid;
  logic [ALU_CTRL_W-1:0] r_alu;
  logic                  r_rw, r_mr, r_mw, r_br, r_jp, r_src, r_ill;
  logic [XLEN-1:0]       r_imm;
  logic [4:0]            r_rs1, r_rs2, r_rd;
  logic [2:0]            r_f3;
  logic [CNT_W-1:0]      r_cnt;

  assign w_opcode = i_instr_word[6:0];
  assign w_f3     = i_instr_word[14:12];
  assign w_f7     = i_instr_word[31:25];

  assign w_imm_i = XLEN'($signed(i_instr_word[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr_word[31:25], i_instr_word[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr_word[31], i_instr_word[7], i_instr_word[30:25],
                                  i_instr_word[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr_word[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_instr_word[31], i_instr_word[19:12], i_instr_word[20],
                                  i_instr_word[30:21], 1'b0}));

  always_comb begin
    w_alu = ALU_ADD;
    w_rw  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_br  = 1'b0;
    w_jp  = 1'b0;
    w_src = 1'b0;
    w_ill = 1'b0;
    w_imm = '0;
    case (w_opcode)
      OP_R: begin
        w_rw = 1'b1;
        if (w_f7 == F7_ZERO)
          w_alu = alu_from_f3(w_f3, 1'b0);
        else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))
          w_alu = alu_from_f3(w_f3, 1'b1);
        else
          w_ill = 1'b1;
      end
      OP_I_ALU: begin
        w_rw  = 1'b1;
        w_src = 1'b1;
        w_imm = w_imm_i;
        w_alu = alu_from_f3(w_f3, 1'b0);
        if (w_f3 == 3'b001 && w_f7 != F7_ZERO)
          w_ill = 1'b1;
        else if (w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)
            w_alu = ALU_SRA;
          else if (w_f7 != F7_ZERO)
            w_ill = 1'b1;
        end
      end
      OP_LOAD: begin
        w_mr  = 1'b1;
        w_rw  = 1'b1;
        w_src = 1'b1;
        w_imm = w_imm_i;
      end
      OP_STORE: begin
        w_mw  = 1'b1;
        w_src = 1'b1;
        w_imm = w_imm_s;
      end
      OP_BRANCH: begin
        w_br  = 1'b1;
        w_alu = ALU_SUB;
        w_imm = w_imm_b;
        if (w_f3 == 3'b010 || w_f3 == 3'b011)
          w_ill = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_rw  = 1'b1;
        w_src = 1'b1;
        w_imm = w_imm_u;
      end
      OP_JAL: begin
        w_jp  = 1'b1;
        w_rw  = 1'b1;
        w_imm = w_imm_j;
      end
      OP_JALR: begin
        w_jp  = 1'b1;
        w_rw  = 1'b1;
        w_src = 1'b1;
        w_imm = w_imm_i;
        if (w_f3 != 3'b000)
          w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // an illegal word carries no side effects downstream
    if (w_ill) begin
      w_alu = ALU_ADD;
      w_rw  = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_br  = 1'b0;
      w_jp  = 1'b0;
      w_src = 1'b0;
      w_imm = '0;
    end
  end

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_alu       <= ALU_ADD;
      r_rw        <= 1'b0;
      r_mr        <= 1'b0;
      r_mw        <= 1'b0;
      r_br        <= 1'b0;
      r_jp        <= 1'b0;
      r_src       <= 1'b0;
      r_ill       <= 1'b0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_f3        <= '0;
      r_cnt       <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu       <= w_alu;
      r_rw        <= w_rw;
      r_mr        <= w_mr;
      r_mw        <= w_mw;
      r_br        <= w_br;
      r_jp        <= w_jp;
      r_src       <= w_src;
      r_ill       <= w_ill;
      r_imm       <= w_imm;
      r_rs1       <= i_instr_word[19:15];
      r_rs2       <= i_instr_word[24:20];
      r_rd        <= i_instr_word[11:7];
      r_f3        <= w_f3;
      if (w_ill && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_alu_ctrl      = r_alu;
  assign o_reg_write     = r_rw;
  assign o_mem_read      = r_mr;
  assign o_mem_write     = r_mw;
  assign o_branch        = r_br;
  assign o_jump          = r_jp;
  assign o_alu_src_imm   = r_src;
  assign o_imm           = r_imm;
  assign o_rs1           = r_rs1;
  assign o_rs2           = r_rs2;
  assign o_rd            = r_rd;
  assign o_funct3        = r_f3;
  assign o_illegal       = r_ill;
  assign o_illegal_count = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: a decode vector table streamed
// back-to-back, then backpressure, flush, drain, saturation and reset sequences.
module tb_decode_ctrl_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_in_valid, i_flush, i_out_ready;
  logic [31:0] i_instr_word;
  logic        o_in_ready, o_out_valid;
  logic [3:0]  o_alu_ctrl;
  logic        o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src_imm;
  logic [31:0] o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_funct3;
  logic        o_illegal;
  logic [7:0]  o_illegal_count;

  decode_ctrl_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_instr_word(i_instr_word), .i_flush(i_flush), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_alu_ctrl(o_alu_ctrl), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
    .o_jump(o_jump), .o_alu_src_imm(o_alu_src_imm), .o_imm(o_imm), .o_rs1(o_rs1),
    .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3), .o_illegal(o_illegal),
    .o_illegal_count(o_illegal_count)
  );

  always #5 i_clk = ~i_clk;

  // ctl = {reg_write, mem_read, mem_write, branch, jump, alu_src_imm}
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [5:0]  ctl;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic [3:0] alu, input logic [5:0] ctl,
                     input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.alu = alu; v.ctl = ctl; v.imm = imm; v.ill = ill;
    vecs.push_back(v);
  endtask

  function automatic logic [5:0] ctl_now();
    return {o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src_imm};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_valid"}, 32'(o_out_valid), 32'd0);
    chk({tag, " alu"},       32'(o_alu_ctrl), 32'h2);
    chk({tag, " ctl"},       32'(ctl_now()), 32'd0);
    chk({tag, " imm"},       o_imm, 32'd0);
    chk({tag, " regs"},      32'({o_rs1, o_rs2, o_rd, o_funct3}), 32'd0);
    chk({tag, " illegal"},   32'(o_illegal), 32'd0);
    chk({tag, " count"},     32'(o_illegal_count), 32'd0);
  endtask

  initial begin
    add(32'h002081B3, 4'b0010, 6'b100000, 32'h0, 1'b0);        // ADD
    add(32'h402081B3, 4'b0100, 6'b100000, 32'h0, 1'b0);        // SUB
    add(32'hFFF00093, 4'b0010, 6'b100001, 32'hFFFFFFFF, 1'b0); // ADDI -1
    add(32'h40105093, 4'b1001, 6'b100001, 32'h00000401, 1'b0); // SRAI
    add(32'h0000A103, 4'b0010, 6'b110001, 32'h0, 1'b0);        // LW
    add(32'h0020A423, 4'b0010, 6'b001001, 32'h8, 1'b0);        // SW +8
    add(32'hFE20AE23, 4'b0010, 6'b001001, 32'hFFFFFFFC, 1'b0); // SW -4
    add(32'hFE208CE3, 4'b0100, 6'b000100, 32'hFFFFFFF8, 1'b0); // BEQ -8
    add(32'h123452B7, 4'b0010, 6'b100001, 32'h12345000, 1'b0); // LUI
    add(32'hFFFFF297, 4'b0010, 6'b100001, 32'hFFFFF000, 1'b0); // AUIPC
    add(32'h001000EF, 4'b0010, 6'b100010, 32'h00000800, 1'b0); // JAL +2048
    add(32'hFFFFF0EF, 4'b0010, 6'b100010, 32'hFFFFFFFE, 1'b0); // JAL -2
    add(32'h004100E7, 4'b0010, 6'b100011, 32'h4, 1'b0);        // JALR
    add(32'h00513093, 4'b1010, 6'b100001, 32'h5, 1'b0);        // SLTIU
    add(32'hFFF17093, 4'b0000, 6'b100001, 32'hFFFFFFFF, 1'b0); // ANDI
    add(32'h00109093, 4'b0011, 6'b100001, 32'h1, 1'b0);        // SLLI
    add(32'h0020C1B3, 4'b0111, 6'b100000, 32'h0, 1'b0);        // XOR
    add(32'h0020F1B3, 4'b0000, 6'b100000, 32'h0, 1'b0);        // AND
    add(32'h0020A1B3, 4'b1000, 6'b100000, 32'h0, 1'b0);        // SLT
    add(32'h0020D1B3, 4'b0101, 6'b100000, 32'h0, 1'b0);        // SRL
    add(32'h0020E1B3, 4'b0001, 6'b100000, 32'h0, 1'b0);        // OR
    add(32'h4020D1B3, 4'b1001, 6'b100000, 32'h0, 1'b0);        // SRA
    add(32'h002091B3, 4'b0011, 6'b100000, 32'h0, 1'b0);        // SLL
    add(32'h0020B1B3, 4'b1010, 6'b100000, 32'h0, 1'b0);        // SLTU
    add(32'h022081B3, 4'b0010, 6'b000000, 32'h0, 1'b1);        // funct7=0000001
    add(32'h0000007F, 4'b0010, 6'b000000, 32'h0, 1'b1);        // bad opcode
    add(32'hFE20ACE3, 4'b0010, 6'b000000, 32'h0, 1'b1);        // branch funct3 010
    add(32'h004110E7, 4'b0010, 6'b000000, 32'h0, 1'b1);        // JALR funct3 001
    add(32'h40101093, 4'b0010, 6'b000000, 32'h0, 1'b1);        // SLLI funct7 alt
    add(32'h4020C1B3, 4'b0010, 6'b000000, 32'h0, 1'b1);        // XOR funct7 alt
    add(32'h00000013, 4'b0010, 6'b100001, 32'h0, 1'b0);        // NOP

    i_reset = 1'b1; i_in_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b1;
    i_instr_word = 32'h0;
    tick(); tick();
    chk_reset_vals("reset");
    i_reset = 1'b0;
    #1;
    chk("reset in_ready", 32'(o_in_ready), 32'd1);

    // back-to-back stream, one result per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      i_in_valid = 1'b1;
      i_instr_word = vecs[i].instr;
      tick();
      if (vecs[i].ill && exp_cnt < 255) exp_cnt++;
      chk($sformatf("v%0d out_valid", i), 32'(o_out_valid), 32'd1);
      chk($sformatf("v%0d in_ready", i), 32'(o_in_ready), 32'd1);
      chk($sformatf("v%0d alu", i), 32'(o_alu_ctrl), 32'(vecs[i].alu));
      chk($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("v%0d imm", i), o_imm, vecs[i].imm);
      chk($sformatf("v%0d illegal", i), 32'(o_illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d rs1", i), 32'(o_rs1), 32'(vecs[i].instr[19:15]));
      chk($sformatf("v%0d rs2", i), 32'(o_rs2), 32'(vecs[i].instr[24:20]));
      chk($sformatf("v%0d rd", i), 32'(o_rd), 32'(vecs[i].instr[11:7]));
      chk($sformatf("v%0d funct3", i), 32'(o_funct3), 32'(vecs[i].instr[14:12]));
      chk($sformatf("v%0d count", i), 32'(o_illegal_count), 32'(exp_cnt));
    end

    // backpressure: LW held while ADD waits
    i_instr_word = 32'h0000A103;
    tick();
    i_out_ready = 1'b0;
    i_instr_word = 32'h002081B3;
    #1;
    chk("bp in_ready low", 32'(o_in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp out_valid", 32'(o_out_valid), 32'd1);
      chk("bp ctl held", 32'(ctl_now()), 32'b110001);
      chk("bp rd held", 32'(o_rd), 32'd2);
      chk("bp funct3 held", 32'(o_funct3), 32'd2);
    end
    i_out_ready = 1'b1;
    tick();
    chk("bp release ctl", 32'(ctl_now()), 32'b100000);
    chk("bp release rd", 32'(o_rd), 32'd3);
    chk("bp release valid", 32'(o_out_valid), 32'd1);

    // flush beats an incoming illegal word
    i_instr_word = 32'h0000007F;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    chk("flush out_valid", 32'(o_out_valid), 32'd0);
    chk("flush count", 32'(o_illegal_count), 32'(exp_cnt));
    chk("flush illegal", 32'(o_illegal), 32'd0);

    // drain without accept keeps the payload
    i_in_valid = 1'b1;
    i_instr_word = 32'h402081B3;
    tick();
    i_in_valid = 1'b0;
    chk("drain pre valid", 32'(o_out_valid), 32'd1);
    tick();
    chk("drain out_valid", 32'(o_out_valid), 32'd0);
    chk("drain alu held", 32'(o_alu_ctrl), 32'b0100);
    chk("drain rd held", 32'(o_rd), 32'd3);

    // saturation of the illegal counter
    i_in_valid = 1'b1;
    i_instr_word = 32'h0000007F;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
    end
    chk("sat count", 32'(o_illegal_count), 32'd255);
    chk("sat model", 32'(o_illegal_count), 32'(exp_cnt));
    chk("sat illegal", 32'(o_illegal), 32'd1);

    // reset mid-stream
    i_instr_word = 32'hFFF00093;
    tick();
    chk("pre-reset imm", o_imm, 32'hFFFFFFFF);
    i_reset = 1'b1;
    i_instr_word = 32'h0000A103;
    tick();
    chk_reset_vals("midreset");
    i_reset = 1'b0;
    i_in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Registered, parametrised control/decode stage between the IFU and the ALU/register-file writeback. It accepts one 32-bit instruction per handshake and decodes RV32I R, I, S, B, U and J formats. The result is held in a single pipeline register: ALU control, writeback enable, memory/branch/jump controls, sign-extended immediate and register indices. It adds valid/ready flow control, flush, illegal-instruction detection and an illegal-instruction counter.

Parameters:
XLEN, 32, datapath width; the immediate output is sign-extended to XLEN.
ALU_CTRL_W, 4, width of alu_ctrl.
CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  instr_word is valid
in_ready  output  1  stage can accept instr_word this cycle
instr_word  input  32  instruction from IFU
flush  input  1  discard the held and incoming instruction
out_valid  output  1  decoded fields valid
out_ready  input  1  consumer accepts decoded fields
alu_ctrl  output  ALU_CTRL_W  ALU operation code
reg_write  output  1  write rd
mem_read  output  1  load
mem_write  output  1  store
branch  output  1  conditional branch
jump  output  1  JAL/JALR
alu_src_imm  output  1  ALU operand B is imm
imm  output  XLEN  sign-extended immediate
rs1, rs2, rd  output  5 each  register indices
funct3  output  3  passed through for branch/load/store sizing
illegal  output  1  instruction not decodable
illegal_count  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything else. On reset all outputs are 0, except alu_ctrl = 4'b0010 (ADD). illegal_count = 0.
- in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready.
- Latency is 1 cycle: fields decoded from the accepted word appear with out_valid=1 on the next edge.
- If out_valid && !out_ready, all outputs hold stable.
- Accept and drain in the same cycle gives back-to-back throughput of 1 instruction per cycle.
- Drain without accept: out_valid falls to 0, and the payload holds its last value.
- flush (no reset) forces out_valid=0 next cycle and ignores the current in_valid; flush has priority over accept. illegal_count is not incremented by flushed words.
- ALU codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, XOR 0111, SLT 1000, SRA 1001, SLTU 1010.
- R-type (0110011), reg_write=1:
  - funct7=0000000 allowed for all funct3.
  - funct7=0100000 allowed only with funct3 000 (SUB) or 101 (SRA).
  - Anything else is illegal.
- I-ALU (0010011), alu_src_imm=1, reg_write=1:
  - Same funct3 mapping as R-type; ADDI cannot be SUB.
  - Shifts require funct7 0000000 (SLLI/SRLI) or 0100000 (SRAI only); otherwise illegal.
- LOAD (0000011): mem_read=1, reg_write=1, alu_src_imm=1, ADD, I-immediate.
- STORE (0100011): mem_write=1, alu_src_imm=1, ADD, S-immediate.
- BRANCH (1100011): branch=1, SUB, B-immediate (bit0=0). funct3 010 and 011 are illegal.
- LUI (0110111) and AUIPC (0010111): reg_write=1, alu_src_imm=1, ADD, U-immediate (low 12 bits 0).
- JAL (1101111): jump=1, reg_write=1, J-immediate.
- JALR (1100111, funct3 000 only): jump=1, reg_write=1, alu_src_imm=1, ADD, I-immediate.
- Any other opcode is illegal.
- An illegal instruction produces illegal=1, reg_write=mem_read=mem_write=branch=jump=0, alu_ctrl=ADD, imm=0.
- illegal_count increments by 1 for each accepted illegal word and saturates at 2^CNT_W-1 (no wrap).
- All control outputs are fully defined for every input: no latches, no case without a default.
- rs1/rs2/rd/funct3 are always the raw instruction fields.

Test Plan:
- Reset, then in_valid=1 with 0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, reg_write=1, rd=3, rs1=1, rs2=2, illegal=0.
- Back-to-back stream 0x402081B3 (SUB), 0xFFF00093 (ADDI x1,x0,-1), 0x40105093 (SRAI) -> alu_ctrl 0100, 0010 with imm=0xFFFFFFFF and alu_src_imm=1, then 1001; one result per cycle with in_ready held at 1.
- Backpressure: out_ready=0 while 0x0000A103 (LW) is held -> outputs are stable, in_ready=0, and the next word is not consumed until out_ready=1.
- Illegal 0x022081B3 (funct7=0000001) and opcode 0x0000007F -> illegal=1, reg_write=0, illegal_count advances 0->2. Drive 300 illegal words -> illegal_count saturates at 255.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and illegal_count unchanged. Reset asserted mid-stream -> all outputs return to reset values on the next edge.
